// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the counting-pattern AXI-Stream packet generator
// and neighbouring 8-bit stream stages.
package axis_pkt_gen_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } pkt_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } axis_beat_t;

endpackage

// File: rtl/axis_gap_timer.sv
// Loadable down-counter; expired is high on the final cycle of the loaded
// interval (count of 1) and whenever the counter is idle at 0.
module axis_gap_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  // Load has priority; otherwise count down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt <= WIDTH'(1));

endmodule

// File: rtl/axis_pkt_gen.sv
// Burst packet source: counting-byte payload, programmable packet length,
// fixed inter-packet gap, AXI-Stream master with backpressure.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  pkt_state_t        state, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  beat_rem, beat_rem_n;
  logic [CNT_W-1:0]  pkt_rem, pkt_rem_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, last_n, busy_n, done_n;
  logic              gap_load, gap_expired;

  axis_gap_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_CYCLES)),
    .expired  (gap_expired)
  );

  // State and every output are registered; next values come from the block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      beat_rem <= '0;
      pkt_rem  <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      beat_rem <= beat_rem_n;
      pkt_rem  <= pkt_rem_n;
      m_data   <= data_n;
      m_valid  <= valid_n;
      m_last   <= last_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output logic; counters count remaining beats/packets
  // so that maximum lengths never need a value beyond the port width.
  always_comb begin
    state_n    = state;
    len_n      = len_q;
    beat_rem_n = beat_rem;
    pkt_rem_n  = pkt_rem;
    data_n     = m_data;
    valid_n    = m_valid;
    last_n     = m_last;
    busy_n     = busy;
    done_n     = 1'b0;
    gap_load   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          if (pkt_len != '0 && num_pkts != '0) begin
            state_n    = ST_SEND;
            len_n      = pkt_len;
            beat_rem_n = pkt_len;
            pkt_rem_n  = num_pkts;
            data_n     = seed;
            valid_n    = 1'b1;
            last_n     = (pkt_len == LEN_W'(1));
            busy_n     = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (m_valid && m_ready) begin
          data_n = m_data + DATA_W'(1);
          if (m_last) begin
            if (pkt_rem == CNT_W'(1)) begin
              state_n = ST_FIN;
              valid_n = 1'b0;
              last_n  = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              pkt_rem_n  = pkt_rem - CNT_W'(1);
              beat_rem_n = len_q;
              if (GAP_CYCLES > 0) begin
                state_n  = ST_GAP;
                valid_n  = 1'b0;
                last_n   = 1'b0;
                gap_load = 1'b1;
              end else begin
                valid_n = 1'b1;
                last_n  = (len_q == LEN_W'(1));
              end
            end
          end else begin
            beat_rem_n = beat_rem - LEN_W'(1);
            last_n     = (beat_rem == LEN_W'(2));
          end
        end
      end

      ST_GAP: begin
        if (gap_expired) begin
          state_n = ST_SEND;
          valid_n = 1'b1;
          last_n  = (len_q == LEN_W'(1));
        end
      end

      ST_FIN: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: one instance with a 2-cycle gap, one
// with back-to-back packets.
module tb_axis_pkt_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic [7:0] pkt_len, num_pkts, seed;
  logic       m_ready;

  logic       busy, done, m_valid, m_last;
  logic [7:0] m_data;
  logic       busy0, done0, m_valid0, m_last0;
  logic [7:0] m_data0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_pkt_gen #(.DATA_W(8), .LEN_W(8), .CNT_W(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .seed(seed), .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  axis_pkt_gen #(.DATA_W(8), .LEN_W(8), .CNT_W(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .seed(seed), .busy(busy0), .done(done0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .m_last(m_last0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".data"},  32'(m_data),  32'(d));
    chk({tag, ".last"},  32'(m_last),  32'(l));
    chk({tag, ".busy"},  32'(busy),    32'd1);
  endtask

  task automatic beat0(input string tag, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(m_valid0), 32'd1);
    chk({tag, ".data"},  32'(m_data0),  32'(d));
    chk({tag, ".last"},  32'(m_last0),  32'(l));
  endtask

  task automatic idle_chk(input string tag, input logic exp_done);
    chk({tag, ".valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".last"},  32'(m_last),  32'd0);
    chk({tag, ".busy"},  32'(busy),    32'd0);
    chk({tag, ".done"},  32'(done),    32'(exp_done));
  endtask

  task automatic req(input logic [7:0] s, input logic [7:0] l, input logic [7:0] n);
    seed = s; pkt_len = l; num_pkts = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int          idx;
    int          cyc;

    rst = 1'b1; start = 1'b0; start0 = 1'b0; m_ready = 1'b1;
    pkt_len = '0; num_pkts = '0; seed = '0;
    repeat (2) @(negedge clk);
    idle_chk("reset", 1'b0);
    chk("reset.data", 32'(m_data), 32'h0);
    chk("reset0.valid", 32'(m_valid0), 32'd0);
    chk("reset0.done", 32'(done0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single packet of four beats at full throughput.
    req(8'h10, 8'd4, 8'd1);
    beat("t1.b0", 8'h10, 1'b0);
    start = 1'b1;                       // ignored while busy
    @(negedge clk); start = 1'b0;
    beat("t1.b1", 8'h11, 1'b0); @(negedge clk);
    beat("t1.b2", 8'h12, 1'b0); @(negedge clk);
    beat("t1.b3", 8'h13, 1'b1); @(negedge clk);
    idle_chk("t1.fin", 1'b1);
    start = 1'b1;                       // sampled in FIN: ignored
    @(negedge clk); start = 1'b0;
    idle_chk("t1.idle", 1'b0);
    @(negedge clk);
    idle_chk("t1.idle2", 1'b0);

    // Two packets with wrap across 0xFF and a two-cycle gap.
    req(8'hFE, 8'd3, 8'd2);
    beat("t2.a0", 8'hFE, 1'b0); @(negedge clk);
    beat("t2.a1", 8'hFF, 1'b0); @(negedge clk);
    beat("t2.a2", 8'h00, 1'b1); @(negedge clk);
    chk("t2.gap1.valid", 32'(m_valid), 32'd0);
    chk("t2.gap1.busy",  32'(busy),    32'd1);
    @(negedge clk);
    chk("t2.gap2.valid", 32'(m_valid), 32'd0);
    chk("t2.gap2.done",  32'(done),    32'd0);
    @(negedge clk);
    beat("t2.b0", 8'h01, 1'b0); @(negedge clk);
    beat("t2.b1", 8'h02, 1'b0); @(negedge clk);
    beat("t2.b2", 8'h03, 1'b1); @(negedge clk);
    idle_chk("t2.fin", 1'b1);
    @(negedge clk);

    // Backpressure: stalls must hold data/last, exactly five transfers.
    pat = 16'b1111_1110_1010_1001;      // applied LSB first
    m_ready = 1'b0;
    req(8'h40, 8'd5, 8'd1);
    idx = 0; cyc = 0;
    while (idx < 5 && cyc < 16) begin
      beat($sformatf("t3.c%0d", cyc), 8'(8'h40 + idx), idx == 4);
      m_ready = pat[cyc];
      if (m_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("t3.transfers", 32'(idx), 32'd5);
    idle_chk("t3.fin", 1'b1);
    m_ready = 1'b1;
    @(negedge clk);

    // Zero-length and zero-count requests are rejected with a done pulse.
    req(8'h33, 8'd0, 8'd3);
    idle_chk("t4.len0", 1'b1);
    @(negedge clk);
    idle_chk("t4.len0.after", 1'b0);
    req(8'h33, 8'd2, 8'd0);
    idle_chk("t4.num0", 1'b1);
    @(negedge clk);
    idle_chk("t4.num0.after", 1'b0);

    // Reset mid-packet, then a clean restart.
    req(8'h50, 8'd6, 8'd1);
    beat("t5.b0", 8'h50, 1'b0); @(negedge clk);
    beat("t5.b1", 8'h51, 1'b0); @(negedge clk);
    beat("t5.b2", 8'h52, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_chk("t5.rst", 1'b0);
    chk("t5.rst.data", 32'(m_data), 32'h0);
    req(8'hA0, 8'd2, 8'd1);
    beat("t5.r0", 8'hA0, 1'b0); @(negedge clk);
    beat("t5.r1", 8'hA1, 1'b1); @(negedge clk);
    idle_chk("t5.fin", 1'b1);
    @(negedge clk);

    // Zero-gap instance: single-beat packets back to back.
    seed = 8'h00; pkt_len = 8'd1; num_pkts = 8'd3; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    beat0("t6.p0", 8'h00, 1'b1); @(negedge clk);
    beat0("t6.p1", 8'h01, 1'b1); @(negedge clk);
    beat0("t6.p2", 8'h02, 1'b1); @(negedge clk);
    chk("t6.fin.valid", 32'(m_valid0), 32'd0);
    chk("t6.fin.done",  32'(done0),    32'd1);
    chk("t6.fin.busy",  32'(busy0),    32'd0);
    @(negedge clk);
    chk("t6.idle.done", 32'(done0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
